// File: rtl/noc_packetizer.sv
// noc_packetizer: turns a core packet request plus payload bytes into header/body flits for the
// local router port, throttled by credits that mirror the free slots of the router's local FIFO.
module noc_packetizer #(
    parameter logic SRC_X   = 1'b0,
    parameter logic SRC_Y   = 1'b0,
    parameter int   CREDITS = 4,
    parameter int   CW      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    input  logic [1:0] pkt_dst,
    input  logic [3:0] pkt_len,
    input  logic       dat_valid,
    output logic       dat_ready,
    input  logic [7:0] dat_in,
    output logic [7:0] flit_out,
    output logic       flit_write,
    input  logic       credit_in,
    output logic       pkt_done,
    output logic       busy,
    output logic       credit_err
);
    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
    localparam logic [CW-1:0] FULL = CW'(CREDITS);
    state_t        state;
    logic [1:0]    dst;
    logic [3:0]    len;
    logic [3:0]    remaining;
    logic [CW-1:0] credits;
    logic          has_credit;
    logic          consume;
    assign has_credit = credits != '0;
    assign consume    = has_credit && (state == HEAD || (state == BODY && dat_valid));
    assign pkt_ready  = state == IDLE;
    assign dat_ready  = state == BODY && has_credit;
    assign busy       = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dst        <= 2'b00;
            len        <= 4'd0;
            remaining  <= 4'd0;
            credits    <= FULL;
            flit_out   <= 8'h00;
            flit_write <= 1'b0;
            pkt_done   <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            flit_write <= consume;
            pkt_done   <= 1'b0;
            // a returned credit with nothing consumed while already full means the router over-returned
            if (credit_in && !consume) begin
                if (credits == FULL) credit_err <= 1'b1;
                else credits <= credits + CW'(1);
            end else if (consume && !credit_in) begin
                credits <= credits - CW'(1);
            end
            case (state)
                IDLE: if (pkt_valid) begin
                    dst   <= pkt_dst;
                    len   <= pkt_len;
                    state <= HEAD;
                end
                HEAD: if (has_credit) begin
                    flit_out  <= {dst[0], dst[1], SRC_X, SRC_Y, len};
                    remaining <= len;
                    state     <= (len == 4'd0) ? IDLE : BODY;
                    pkt_done  <= len == 4'd0;
                end
                BODY: if (consume) begin
                    flit_out  <= dat_in;
                    remaining <= remaining - 4'd1;
                    state     <= (remaining == 4'd1) ? IDLE : BODY;
                    pkt_done  <= remaining == 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: directed packets against a flit-queue and credit-count model of the packetizer,
// with hand-computed flit values and cycle positions for each scenario.
module tb_noc_packetizer;
    localparam int CREDITS = 4;
    localparam logic SRC_X = 1'b0;
    localparam logic SRC_Y = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pkt_valid = 1'b0;
    logic       pkt_ready;
    logic [1:0] pkt_dst = 2'b00;
    logic [3:0] pkt_len = 4'd0;
    logic       dat_valid = 1'b0;
    logic       dat_ready;
    logic [7:0] dat_in = 8'h00;
    logic [7:0] flit_out;
    logic       flit_write;
    logic       credit_in = 1'b0;
    logic       pkt_done;
    logic       busy;
    logic       credit_err;

    noc_packetizer #(.SRC_X(SRC_X), .SRC_Y(SRC_Y), .CREDITS(CREDITS), .CW(3)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dst(pkt_dst),
        .pkt_len(pkt_len), .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in),
        .flit_out(flit_out), .flit_write(flit_write), .credit_in(credit_in), .pkt_done(pkt_done),
        .busy(busy), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] f; logic d;} exp_t;
    typedef struct {int cyc; logic [7:0] f; logic d;} rec_t;
    exp_t       exp_q[$];
    rec_t       wr_q[$];
    logic [7:0] src_q[$];
    int         compared = 0;
    int         mismatched = 0;
    int         cyc = 0;
    int         acc_cyc = 0;

    function automatic void check(string n, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endfunction

    // model: every written flit must match the next expected flit, and writes may only happen with credit left
    initial begin
        int   mc;
        bit   merr;
        logic cin_s;
        exp_t e;
        mc = CREDITS;
        merr = 0;
        forever begin
            @(posedge clk);
            cyc++;
            cin_s = credit_in;
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mc = CREDITS;
                merr = 0;
            end else begin
                if (flit_write) begin
                    check("write_with_credit", int'(mc > 0), 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_flit", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("flit_out", int'(flit_out), int'(e.f));
                        check("pkt_done", int'(pkt_done), int'(e.d));
                    end
                    wr_q.push_back('{cyc, flit_out, pkt_done});
                end else begin
                    check("done_without_write", int'(pkt_done), 0);
                end
                mc = mc - int'(flit_write) + int'(cin_s);
                if (mc > CREDITS) begin
                    mc = CREDITS;
                    merr = 1;
                end
                check("credit_err", int'(credit_err), int'(merr));
            end
        end
    end

    // payload source: presents queued bytes, advances on an observed handshake
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = dat_valid && dat_ready;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            dat_valid = src_q.size() > 0;
            dat_in = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d, input logic [3:0] l, input logic [7:0] base,
                        input logic [7:0] step, input int nb, input bit hold);
        bit ok;
        logic [7:0] b;
        exp_q.push_back('{{d[0], d[1], SRC_X, SRC_Y, l}, l == 4'd0});
        b = base;
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back('{b, i == int'(l) - 1});
            if (i < nb) src_q.push_back(b);
            b = b + step;
        end
        pkt_dst = d;
        pkt_len = l;
        pkt_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ok = pkt_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        check("accept_timeout", int'(ok), 1);
        acc_cyc = cyc;
        if (!hold) pkt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            idle = !busy;
            if (idle) break;
        end
        check("idle_timeout", int'(idle), 1);
        wait_cycles(1);
    endtask

    task automatic pulse_credit(output int pc);
        pc = cyc;
        credit_in = 1'b1;
        wait_cycles(1);
        credit_in = 1'b0;
    endtask

    // reset is raised between edges so the asynchronous path is what gets observed
    task automatic do_reset();
        credit_in = 1'b0;
        pkt_valid = 1'b0;
        src_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_flit_out", int'(flit_out), 0);
        check("rst_flit_write", int'(flit_write), 0);
        check("rst_pkt_done", int'(pkt_done), 0);
        check("rst_credit_err", int'(credit_err), 0);
        check("rst_pkt_ready", int'(pkt_ready), 1);
        check("rst_dat_ready", int'(dat_ready), 0);
        check("rst_busy", int'(busy), 0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        wr_q.delete();
    endtask

    initial begin
        int pc;
        do_reset();

        // dst=11, len=3, bytes A1,B2,C3 with credit_in held high
        credit_in = 1'b1;
        send(2'b11, 4'd3, 8'hA1, 8'h11, 3, 0);
        wait_idle();
        credit_in = 1'b0;
        check("a_count", wr_q.size(), 4);
        if (wr_q.size() == 4) begin
            check("a_hdr", int'(wr_q[0].f), 'hC3);
            check("a_b0", int'(wr_q[1].f), 'hA1);
            check("a_b1", int'(wr_q[2].f), 'hB2);
            check("a_b2", int'(wr_q[3].f), 'hC3);
            check("a_hdr_latency", wr_q[0].cyc, acc_cyc + 1);
            check("a_consecutive", wr_q[3].cyc, wr_q[0].cyc + 3);
            check("a_done_mid", int'(wr_q[2].d), 0);
            check("a_done_last", int'(wr_q[3].d), 1);
        end
        check("a_credit_err_sat", int'(credit_err), 1);

        // len=0, dst=01: single header flit 80
        do_reset();
        send(2'b01, 4'd0, 8'h00, 8'h00, 0, 0);
        wait_cycles(1);
        check("b_write", int'(flit_write), 1);
        check("b_flit", int'(flit_out), 'h80);
        check("b_done", int'(pkt_done), 1);
        check("b_idle", int'(pkt_ready), 1);
        wait_cycles(1);
        check("b_write_off", int'(flit_write), 0);
        check("b_hold", int'(flit_out), 'h80);

        // backpressure: 4 credits, len=6, then one flit per returned credit
        do_reset();
        send(2'b10, 4'd6, 8'h10, 8'h01, 6, 0);
        wait_cycles(8);
        check("c_stall_count", wr_q.size(), 4);
        check("c_dat_ready", int'(dat_ready), 0);
        check("c_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            pulse_credit(pc);
            wait_cycles(3);
            check("c_release_count", wr_q.size(), 5 + i);
            if (wr_q.size() == 5 + i) check("c_release_cyc", wr_q[4 + i].cyc, pc + 2);
        end
        if (wr_q.size() == 7) begin
            check("c_last_flit", int'(wr_q[6].f), 'h15);
            check("c_done_7th", int'(wr_q[6].d), 1);
            check("c_done_6th", int'(wr_q[5].d), 0);
        end
        check("c_idle", int'(busy), 0);

        // credit returned on the header write with credits=2 leaves 2: header plus 2 bodies then stall
        do_reset();
        send(2'b00, 4'd1, 8'h77, 8'h00, 1, 0);
        wait_idle();
        wr_q.delete();
        send(2'b11, 4'd3, 8'h20, 8'h20, 3, 0);
        pulse_credit(pc);
        wait_cycles(7);
        check("d_count", wr_q.size(), 3);
        check("d_dat_ready", int'(dat_ready), 0);
        pulse_credit(pc);
        wait_cycles(3);
        check("d_finish_count", wr_q.size(), 4);
        check("d_idle", int'(busy), 0);
        credit_in = 1'b1;
        wait_cycles(4);
        credit_in = 1'b0;
        wait_cycles(1);
        check("d_refill_no_err", int'(credit_err), 0);
        pulse_credit(pc);
        wait_cycles(1);
        check("d_over_credit", int'(credit_err), 1);
        wait_cycles(5);
        check("d_err_sticky", int'(credit_err), 1);

        // back-to-back with pkt_valid held: one idle write cycle between packets
        do_reset();
        send(2'b10, 4'd1, 8'h55, 8'h00, 1, 1);
        send(2'b00, 4'd1, 8'h66, 8'h00, 1, 0);
        wait_idle();
        check("e_count", wr_q.size(), 4);
        if (wr_q.size() == 4) begin
            check("e_hdr1", int'(wr_q[0].f), 'h41);
            check("e_body1", int'(wr_q[1].f), 'h55);
            check("e_hdr2", int'(wr_q[2].f), 'h01);
            check("e_body2", int'(wr_q[3].f), 'h66);
            check("e_gap", wr_q[2].cyc - wr_q[1].cyc, 2);
            check("e_tail1_done", int'(wr_q[1].d), 1);
        end

        // reset mid-BODY aborts the packet and restores all 4 credits
        do_reset();
        send(2'b01, 4'd5, 8'h30, 8'h01, 2, 0);
        wait_cycles(6);
        check("f_partial", wr_q.size(), 3);
        check("f_busy", int'(busy), 1);
        do_reset();
        send(2'b01, 4'd3, 8'h90, 8'h01, 3, 0);
        wait_idle();
        check("f_full_credits", wr_q.size(), 4);
        if (wr_q.size() == 4) check("f_hdr", int'(wr_q[0].f), 'h83);
        check("drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
